// File: rtl/left_shifter.sv
// rtl/left_shifter.sv - logical left barrel shifter with registered, valid-tagged output
// Optional build macro: LEFT_SHIFTER_PIPE_EN adds a register stage after the 1/2/4 shift stages.
module left_shifter #(
   parameter  int WIDTH = 32,
   localparam int SHW   = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] in,
   input  logic [SHW-1:0]   sha,
   output logic             out_valid,
   output logic [WIDTH-1:0] out
);

   logic [WIDTH-1:0] out_d, out_q;
   logic             out_valid_d, out_valid_q;

`ifdef LEFT_SHIFTER_PIPE_EN
   // Split point: stages below LO run before the mid register, the rest after it.
   // The split needs at least one stage on each side, so WIDTH must be >= 4 here.
   localparam int LO = (SHW > 3) ? 3 : SHW - 1;
   localparam int HW = SHW - LO;

   logic [WIDTH-1:0] lo_res, hi_res;
   logic [WIDTH-1:0] part_d, part_q;
   logic [HW-1:0]    sha_hi_d, sha_hi_q;
   logic             mid_valid_d, mid_valid_q;

   // Low shift stages (1, 2, 4 positions) ahead of the mid register
   always_comb begin
      lo_res = in;
      for (int k = 0; k < LO; k++) begin
         if (sha[k]) lo_res = lo_res << (1 << k);
      end
   end

   // Mid register captures a new partial result and the remaining shift bits only on valid input
   always_comb begin
      part_d      = part_q;
      sha_hi_d    = sha_hi_q;
      mid_valid_d = in_valid;
      if (in_valid) begin
         part_d   = lo_res;
         sha_hi_d = sha[SHW-1:LO];
      end
   end

   // Mid pipeline register; reset drops any in-flight partial result
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         part_q      <= '0;
         sha_hi_q    <= '0;
         mid_valid_q <= 1'b0;
      end else begin
         part_q      <= part_d;
         sha_hi_q    <= sha_hi_d;
         mid_valid_q <= mid_valid_d;
      end
   end

   // High shift stages (8, 16, ... positions) on the registered partial result
   always_comb begin
      hi_res = part_q;
      for (int k = 0; k < HW; k++) begin
         if (sha_hi_q[k]) hi_res = hi_res << (1 << (k + LO));
      end
   end

   // Output register loads only when the mid stage carries a valid result
   always_comb begin
      out_d       = out_q;
      out_valid_d = mid_valid_q;
      if (mid_valid_q) out_d = hi_res;
   end
`else
   logic [WIDTH-1:0] shift_res;

   // Full log-depth network: stage k shifts by 2^k when sha[k] is set
   always_comb begin
      shift_res = in;
      for (int k = 0; k < SHW; k++) begin
         if (sha[k]) shift_res = shift_res << (1 << k);
      end
   end

   // Output register loads only on valid input and otherwise holds its last result
   always_comb begin
      out_d       = out_q;
      out_valid_d = in_valid;
      if (in_valid) out_d = shift_res;
   end
`endif

   // Output register with asynchronous clear
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_q       <= '0;
         out_valid_q <= 1'b0;
      end else begin
         out_q       <= out_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign out       = out_q;
   assign out_valid = out_valid_q;

endmodule

// File: tb/tb_left_shifter.sv
// tb/tb_left_shifter.sv - directed self-checking bench for left_shifter
module tb_left_shifter;

`ifdef LEFT_SHIFTER_PIPE_EN
   localparam int LAT = 2;
`else
   localparam int LAT = 1;
`endif

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic [31:0] in_s;
   logic [4:0]  sha;
   logic        out_valid;
   logic [31:0] out_s;

   int checks;
   int failures;

   left_shifter #(.WIDTH(32)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .in_valid (in_valid),
      .in       (in_s),
      .sha      (sha),
      .out_valid(out_valid),
      .out      (out_s)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Drives one valid operand, then idles until the result is due, then checks it.
   task automatic run_one(input string name, input logic [31:0] a, input logic [4:0] s,
                          input logic [31:0] exp);
      @(negedge clk);
      in_valid = 1'b1; in_s = a; sha = s;
      @(posedge clk);
      for (int i = 1; i < LAT; i++) begin
         @(negedge clk);
         in_valid = 1'b0;
         @(posedge clk);
      end
      #1;
      checks++;
      if (out_s !== exp) begin
         failures++;
         $display("FAIL %s out actual=%h expected=%h", name, out_s, exp);
      end
      checks++;
      if (out_valid !== 1'b1) begin
         failures++;
         $display("FAIL %s out_valid actual=%b expected=1", name, out_valid);
      end
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b1; in_valid = 1'b0; in_s = '0; sha = '0;
      #2;
      rst_n = 1'b0; in_s = 32'hFFFF_FFFF; sha = 5'd3; in_valid = 1'b1;
      #1;
      checks++;
      if (out_s !== 32'h0) begin
         failures++;
         $display("FAIL reset_async out actual=%h expected=00000000", out_s);
      end
      checks++;
      if (out_valid !== 1'b0) begin
         failures++;
         $display("FAIL reset_async out_valid actual=%b expected=0", out_valid);
      end
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if (out_s !== 32'h0 || out_valid !== 1'b0) begin
         failures++;
         $display("FAIL reset_held out=%h out_valid=%b expected 00000000/0", out_s, out_valid);
      end
      @(negedge clk);
      in_valid = 1'b0;
      rst_n = 1'b1;
   endtask

   task automatic test_basic();
      run_one("basic_321_sh7", 32'd321, 5'd7, 32'h0000_A080);
   endtask

   task automatic test_boundaries();
      run_one("max_shift", 32'hFFFF_FFFF, 5'd31, 32'h8000_0000);
      run_one("zero_shift", 32'h1234_5678, 5'd0, 32'h1234_5678);
      run_one("mixed_shift", 32'h8765_4321, 5'd13, 32'hA864_2000);
   endtask

   task automatic test_back_to_back();
      logic [4:0]  s_tab [5];
      logic [31:0] e_tab [5];
      s_tab = '{5'd1, 5'd2, 5'd4, 5'd8, 5'd16};
      e_tab = '{32'h2, 32'h4, 32'h10, 32'h100, 32'h10000};
      for (int i = 0; i < 5 + LAT - 1; i++) begin
         @(negedge clk);
         if (i < 5) begin
            in_valid = 1'b1; in_s = 32'h1; sha = s_tab[i];
         end else begin
            in_valid = 1'b0;
         end
         @(posedge clk);
         #1;
         if (i >= LAT - 1) begin
            checks++;
            if (out_s !== e_tab[i-LAT+1] || out_valid !== 1'b1) begin
               failures++;
               $display("FAIL stage_%0d out=%h out_valid=%b expected %h/1",
                        i-LAT+1, out_s, out_valid, e_tab[i-LAT+1]);
            end
         end
      end
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic test_hold();
      run_one("hold_setup", 32'd321, 5'd7, 32'h0000_A080);
      // in_valid is already low; the next edge must drop valid and keep data
      @(posedge clk);
      #1;
      checks++;
      if (out_s !== 32'h0000_A080) begin
         failures++;
         $display("FAIL hold out actual=%h expected=0000a080", out_s);
      end
      checks++;
      if (out_valid !== 1'b0) begin
         failures++;
         $display("FAIL hold out_valid actual=%b expected=0", out_valid);
      end
   endtask

   task automatic test_mid_reset();
      @(negedge clk);
      in_valid = 1'b1; in_s = 32'h3; sha = 5'd4;
      @(posedge clk);
      @(negedge clk);
      in_s = 32'h7; sha = 5'd1;
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      checks++;
      if (out_s !== 32'h0 || out_valid !== 1'b0) begin
         failures++;
         $display("FAIL midreset_async out=%h out_valid=%b expected 00000000/0", out_s, out_valid);
      end
      @(negedge clk);
      rst_n = 1'b1;
      in_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk);
         #1;
         checks++;
         if (out_s !== 32'h0 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL midreset_stale_%0d out=%h out_valid=%b expected 00000000/0",
                     i, out_s, out_valid);
         end
      end
      run_one("post_reset", 32'h5, 5'd2, 32'h14);
   endtask

   initial begin
      checks = 0;
      failures = 0;
      test_reset();
      test_basic();
      test_boundaries();
      test_back_to_back();
      test_hold();
      test_mid_reset();
      repeat (2) @(posedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
